axi_lite_arbiter: RTL and testbench

- 2-master, 1-slave AXI4-Lite arbiter sitting directly upstream of the memory-side AXI slave bridge.
- Master 0 is the IFU (read-only); master 1 is the LSU (read/write).
- Grants exactly one outstanding transaction at a time and routes its channels to the slave.
- Holds the grant from address handshake until response handshake.

---
 rtl/axi_lite_arbiter_if.sv | 40 ++++
 rtl/axi_lite_arbiter.sv | 179 +++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite channel bundle (AR, R, AW, W, B) used on both sides of
// axi_lite_arbiter. "master" is the initiator view, "slave" the target view.
interface axi_lite_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-master / one-slave AXI4-Lite arbiter. m0 = IFU (read-only),
// m1 = LSU (read/write). One transaction in flight; the grant is held from
// address handshake until the response handshake. Arbitration is registered:
// IDLE samples requests, the chosen channel is forwarded the following cycle.
// Optional macro ARBITER_ROUND_ROBIN_EN: alternate between IFU and LSU on
// conflict (LSU write still beats LSU read); otherwise fixed priority
// LSU write > LSU read > IFU read.
module axi_lite_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    axi_lite_arbiter_if.slave  m0,
    axi_lite_arbiter_if.slave  m1,
    axi_lite_arbiter_if.master s
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] M0_RD = 2'd1;
    localparam logic [1:0] M1_RD = 2'd2;
    localparam logic [1:0] M1_WR = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              ar_done_q, ar_done_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              wr_req, lsu_req;
    logic [1:0]        lsu_sel, grant_sel;
    logic [ADDR_W-1:0] rd_araddr;
    logic [DATA_W-1:0] rdata_fwd;
    logic              unused_m0_wr;

    // The IFU never writes; its write-side inputs are intentionally ignored.
    assign unused_m0_wr = ^{m0.awaddr, m0.awvalid, m0.wdata, m0.wstrb, m0.wvalid, m0.bready};

    assign wr_req    = m1.awvalid | m1.wvalid;
    assign lsu_req   = wr_req | m1.arvalid;
    assign lsu_sel   = wr_req ? M1_WR : M1_RD;
    assign rd_araddr = (state_q == M1_RD) ? m1.araddr : m0.araddr;
    assign rdata_fwd = s.rdata;

`ifdef ARBITER_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    // Pick a winner in IDLE; on IFU/LSU conflict the side not served last wins
    always_comb begin
        grant_sel = IDLE;
        if (lsu_req && m0.arvalid) grant_sel = last_grant_q ? M0_RD : lsu_sel;
        else if (lsu_req)          grant_sel = lsu_sel;
        else if (m0.arvalid)       grant_sel = M0_RD;
    end

    // Record which side owned the bus as its transaction retires
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q != IDLE && state_d == IDLE) last_grant_d = (state_q != M0_RD);
    end

    // Round-robin history, reset to "LSU served last"
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_grant_q <= 1'b1;
        else      last_grant_q <= last_grant_d;
    end
`else
    // Pick a winner in IDLE with fixed priority: LSU write, LSU read, IFU read
    always_comb begin
        grant_sel = IDLE;
        if (lsu_req)         grant_sel = lsu_sel;
        else if (m0.arvalid) grant_sel = M0_RD;
    end
`endif

    // Next state and per-channel done flags; flags clear whenever we retire
    always_comb begin
        state_d   = state_q;
        ar_done_d = ar_done_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: state_d = grant_sel;
            M0_RD, M1_RD: begin
                if (s.arvalid && s.arready) ar_done_d = 1'b1;
                if (s.rvalid && s.rready) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                end
            end
            M1_WR: begin
                if (s.awvalid && s.awready) aw_done_d = 1'b1;
                if (s.wvalid && s.wready)   w_done_d  = 1'b1;
                if (s.bvalid && s.bready) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers, cleared asynchronously (drops any in-flight response)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Connect the granted master to the slave; all other outputs stay 0
    always_comb begin
        s.araddr   = '0;
        s.arvalid  = 1'b0;
        s.rready   = 1'b0;
        s.awaddr   = '0;
        s.awvalid  = 1'b0;
        s.wdata    = '0;
        s.wstrb    = '0;
        s.wvalid   = 1'b0;
        s.bready   = 1'b0;
        m0.arready = 1'b0;
        m0.rdata   = '0;
        m0.rresp   = '0;
        m0.rvalid  = 1'b0;
        m0.awready = 1'b0;
        m0.wready  = 1'b0;
        m0.bresp   = '0;
        m0.bvalid  = 1'b0;
        m1.arready = 1'b0;
        m1.rdata   = '0;
        m1.rresp   = '0;
        m1.rvalid  = 1'b0;
        m1.awready = 1'b0;
        m1.wready  = 1'b0;
        m1.bresp   = '0;
        m1.bvalid  = 1'b0;
        case (state_q)
            M0_RD: begin
                s.araddr   = rd_araddr;
                s.arvalid  = m0.arvalid & ~ar_done_q;
                m0.arready = s.arready & ~ar_done_q;
                s.rready   = m0.rready;
                m0.rvalid  = s.rvalid;
                m0.rdata   = rdata_fwd;
                m0.rresp   = s.rresp;
            end
            M1_RD: begin
                s.araddr   = rd_araddr;
                s.arvalid  = m1.arvalid & ~ar_done_q;
                m1.arready = s.arready & ~ar_done_q;
                s.rready   = m1.rready;
                m1.rvalid  = s.rvalid;
                m1.rdata   = rdata_fwd;
                m1.rresp   = s.rresp;
            end
            M1_WR: begin
                s.awaddr   = m1.awaddr;
                s.awvalid  = m1.awvalid & ~aw_done_q;
                m1.awready = s.awready & ~aw_done_q;
                s.wdata    = m1.wdata;
                s.wstrb    = m1.wstrb;
                s.wvalid   = m1.wvalid & ~w_done_q;
                m1.wready  = s.wready & ~w_done_q;
                s.bready   = m1.bready;
                m1.bvalid  = s.bvalid;
                m1.bresp   = s.bresp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Self-checking bench for axi_lite_arbiter: bench-driven IFU/LSU masters and a
// randomly stalling slave; a reference model predicts grant order, routing,
// arbitration latency and the single-handshake-per-channel rule.
module tb_axi_lite_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MAXCYC = 300;

    logic clk;
    logic rst;

    axi_lite_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
    axi_lite_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
    axi_lite_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

    axi_lite_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_if),
        .m1  (m1_if),
        .s   (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // master-side state
    bit          m0_req, r1_req, aw_req, w_req;
    int          aw_wait, w_wait;
    logic [31:0] m0_addr, r1_addr, aw_addr, w_data;
    logic [3:0]  w_strb;
    // slave responder state
    bit          sl_rd_busy, sl_aw_got, sl_w_got;
    int          sl_rd_cnt, sl_b_cnt, rd_lat;
    logic [31:0] sl_rd_addr, sl_aw_addr;
    // reference model: 0 = IFU read, 1 = LSU read, 2 = LSU write
    int          exp_q[$];
    bit          model_last_lsu;
    // per-transaction observation
    bit          t_ar_seen, t_aw_seen, t_w_seen, t_started;
    int          next_start, cyc;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a - 32'h8000_0000) ^ 32'h0000_0413;
    endfunction

    function automatic logic [1:0] resp_fn(input logic [31:0] a);
        return a[3:2];
    endfunction

    function automatic logic [31:0] rnd_addr();
        return 32'h8000_0000 | ($urandom & 32'h00FF_FFFC);
    endfunction

    function automatic logic [255:0] all_outs();
        return {s_if.araddr, s_if.arvalid, s_if.rready, s_if.awaddr, s_if.awvalid,
                s_if.wdata, s_if.wstrb, s_if.wvalid, s_if.bready,
                m0_if.arready, m0_if.rdata, m0_if.rresp, m0_if.rvalid,
                m0_if.awready, m0_if.wready, m0_if.bresp, m0_if.bvalid,
                m1_if.arready, m1_if.rdata, m1_if.rresp, m1_if.rvalid,
                m1_if.awready, m1_if.wready, m1_if.bresp, m1_if.bvalid};
    endfunction

    // Predicted service order for requests that are all pending at once.
    task automatic build_order(input bit p0, input bit p1, input bit pw);
        bit a0, a1, aw;
        int pick, lsu_pick;
        a0 = p0; a1 = p1; aw = pw;
        while (a0 | a1 | aw) begin
            lsu_pick = aw ? 2 : 1;
            if (!(a1 | aw))  pick = 0;
            else if (!a0)    pick = lsu_pick;
            else begin
`ifdef ARBITER_ROUND_ROBIN_EN
                pick = model_last_lsu ? 0 : lsu_pick;
`else
                pick = lsu_pick;
`endif
            end
            exp_q.push_back(pick);
            model_last_lsu = (pick != 0);
            if (pick == 0) a0 = 1'b0;
            if (pick == 1) a1 = 1'b0;
            if (pick == 2) aw = 1'b0;
        end
    endtask

    task automatic drive();
        m0_if.araddr  = m0_addr;
        m0_if.arvalid = m0_req;
        m0_if.rready  = 1'($urandom_range(0, 1));
        m0_if.awaddr  = '0;
        m0_if.awvalid = 1'b0;
        m0_if.wdata   = '0;
        m0_if.wstrb   = '0;
        m0_if.wvalid  = 1'b0;
        m0_if.bready  = 1'b0;
        m1_if.araddr  = r1_addr;
        m1_if.arvalid = r1_req;
        m1_if.rready  = 1'($urandom_range(0, 1));
        m1_if.awaddr  = aw_addr;
        m1_if.awvalid = aw_req && (aw_wait == 0);
        m1_if.wdata   = w_data;
        m1_if.wstrb   = w_strb;
        m1_if.wvalid  = w_req && (w_wait == 0);
        m1_if.bready  = 1'($urandom_range(0, 1));
        if (aw_wait > 0) aw_wait--;
        if (w_wait > 0)  w_wait--;
        s_if.arready  = 1'($urandom_range(0, 1));
        s_if.awready  = 1'($urandom_range(0, 1));
        s_if.wready   = 1'($urandom_range(0, 1));
        s_if.rvalid   = sl_rd_busy && (sl_rd_cnt == 0);
        s_if.rdata    = s_if.rvalid ? rd_fn(sl_rd_addr) : $urandom;
        s_if.rresp    = resp_fn(sl_rd_addr);
        if (sl_rd_busy && sl_rd_cnt > 0) sl_rd_cnt--;
        s_if.bvalid   = sl_aw_got && sl_w_got && (sl_b_cnt == 0);
        s_if.bresp    = resp_fn(sl_aw_addr);
        if (sl_aw_got && sl_w_got && sl_b_cnt > 0) sl_b_cnt--;
    endtask

    task automatic finish_txn(input int who, input logic [63:0] obs, input logic [63:0] exp);
        int want;
        want = -1;
        if (exp_q.size() > 0) want = exp_q.pop_front();
        chk("grant_order", who, want);
        if (who == 0) chk("m0_rresp_rdata", obs, exp);
        if (who == 1) chk("m1_rresp_rdata", obs, exp);
        if (who == 2) chk("m1_bresp", obs, exp);
        t_ar_seen  = 1'b0;
        t_aw_seen  = 1'b0;
        t_w_seen   = 1'b0;
        t_started  = 1'b0;
        next_start = cyc + 2;
    endtask

    // Called at negedge: checks current outputs, then books handshakes that
    // complete at the coming rising edge.
    task automatic sample();
        int head;
        head = (exp_q.size() > 0) ? exp_q[0] : -1;
        chk("m0_write_side_quiet", {m0_if.awready, m0_if.wready, m0_if.bvalid, m0_if.bresp}, '0);
        if (head != 0) chk("m0_not_granted", {m0_if.arready, m0_if.rvalid}, '0);
        if (head != 1) chk("m1_rd_not_granted", {m1_if.arready, m1_if.rvalid}, '0);
        if (head != 2) chk("m1_wr_not_granted", {m1_if.awready, m1_if.wready, m1_if.bvalid}, '0);
        if (t_ar_seen) chk("no_dup_s_arvalid", s_if.arvalid, 1'b0);
        if (t_aw_seen) chk("no_dup_s_awvalid", s_if.awvalid, 1'b0);
        if (t_w_seen)  chk("no_dup_s_wvalid", s_if.wvalid, 1'b0);
        if ((s_if.arvalid | s_if.awvalid | s_if.wvalid) && !t_started) begin
            t_started = 1'b1;
            chk("first_slave_valid_cycle", cyc, next_start);
        end
        if (s_if.arvalid && s_if.arready) begin
            chk("s_araddr", s_if.araddr, (head == 0) ? m0_addr : (head == 1) ? r1_addr : 32'hxxxx_xxxx);
            t_ar_seen  = 1'b1;
            sl_rd_busy = 1'b1;
            sl_rd_addr = s_if.araddr;
            sl_rd_cnt  = $urandom_range(0, rd_lat);
        end
        if (s_if.awvalid && s_if.awready) begin
            chk("s_awaddr", s_if.awaddr, (head == 2) ? aw_addr : 32'hxxxx_xxxx);
            t_aw_seen  = 1'b1;
            sl_aw_got  = 1'b1;
            sl_aw_addr = s_if.awaddr;
            sl_b_cnt   = $urandom_range(0, rd_lat);
        end
        if (s_if.wvalid && s_if.wready) begin
            chk("s_wstrb_wdata", {s_if.wstrb, s_if.wdata}, (head == 2) ? {w_strb, w_data} : 36'hx_xxxx_xxxx);
            t_w_seen = 1'b1;
            sl_w_got = 1'b1;
        end
        if (s_if.rvalid && s_if.rready) sl_rd_busy = 1'b0;
        if (s_if.bvalid && s_if.bready) begin
            sl_aw_got = 1'b0;
            sl_w_got  = 1'b0;
        end
        if (m0_if.arvalid && m0_if.arready) m0_req = 1'b0;
        if (m1_if.arvalid && m1_if.arready) r1_req = 1'b0;
        if (m1_if.awvalid && m1_if.awready) aw_req = 1'b0;
        if (m1_if.wvalid && m1_if.wready)   w_req  = 1'b0;
        if (m0_if.rvalid && m0_if.rready)
            finish_txn(0, {m0_if.rresp, m0_if.rdata}, {resp_fn(m0_addr), rd_fn(m0_addr)});
        if (m1_if.rvalid && m1_if.rready)
            finish_txn(1, {m1_if.rresp, m1_if.rdata}, {resp_fn(r1_addr), rd_fn(r1_addr)});
        if (m1_if.bvalid && m1_if.bready)
            finish_txn(2, m1_if.bresp, resp_fn(aw_addr));
    endtask

    // Raise the selected requests together and run until all are served.
    task automatic run_scn(input bit d0, input bit d1, input bit dw,
                           input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] aa,
                           input logic [31:0] wd, input logic [3:0] ws,
                           input int awd, input int wdl, input bit stop_aw);
        build_order(d0, d1, dw);
        m0_addr = a0; r1_addr = a1; aw_addr = aa; w_data = wd; w_strb = ws;
        m0_req = d0; r1_req = d1; aw_req = dw; w_req = dw;
        aw_wait = awd; w_wait = wdl;
        t_ar_seen = 1'b0; t_aw_seen = 1'b0; t_w_seen = 1'b0; t_started = 1'b0;
        next_start = 1;
        cyc = 0;
        @(posedge clk); #1; drive();
        for (int i = 0; i < MAXCYC; i++) begin
            @(negedge clk);
            cyc = i;
            sample();
            if (stop_aw && t_aw_seen) return;
            if (exp_q.size() == 0) break;
            @(posedge clk); #1; drive();
        end
        chk("scenario_drained", exp_q.size(), 0);
    endtask

    initial begin
        bit d0, d1, dw, aw_late;
        int dly;
        rst = 1'b0;
        m0_req = 1'b1; r1_req = 1'b1; aw_req = 1'b0; w_req = 1'b0;
        aw_wait = 0; w_wait = 0;
        m0_addr = 32'h8000_0000; r1_addr = 32'h8000_0100; aw_addr = '0; w_data = '0; w_strb = '0;
        sl_rd_busy = 1'b0; sl_aw_got = 1'b0; sl_w_got = 1'b0;
        sl_rd_cnt = 0; sl_b_cnt = 0; sl_rd_addr = '0; sl_aw_addr = '0;
        rd_lat = 2;
        model_last_lsu = 1'b1;
        t_ar_seen = 1'b0; t_aw_seen = 1'b0; t_w_seen = 1'b0; t_started = 1'b0;
        next_start = 1; cyc = 0;
        drive();
        repeat (3) @(negedge clk);
        chk("reset_outputs_with_requests", all_outs(), '0);
        m0_req = 1'b0; r1_req = 1'b0;
        drive();
        rst = 1'b1;
        @(negedge clk);
        chk("idle_outputs", all_outs(), '0);

        // IFU read alone
        run_scn(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0100, 32'h8000_0200, 32'h0, 4'h0, 0, 0, 1'b0);
        // IFU and LSU read together
        run_scn(1'b1, 1'b1, 1'b0, 32'h8000_0004, 32'h8000_0100, 32'h8000_0200, 32'h0, 4'h0, 0, 0, 1'b0);
        // LSU write, W two cycles ahead of AW
        run_scn(1'b0, 1'b0, 1'b1, 32'h8000_0008, 32'h8000_0104, 32'h8000_0200, 32'hDEAD_BEEF, 4'hF, 2, 0, 1'b0);
        // LSU write and read together
        run_scn(1'b0, 1'b1, 1'b1, 32'h8000_000C, 32'h8000_0108, 32'h8000_0204, 32'hCAFE_F00D, 4'h5, 0, 0, 1'b0);
        // everything at once
        run_scn(1'b1, 1'b1, 1'b1, 32'h8000_0010, 32'h8000_010C, 32'h8000_0208, 32'h0BAD_F00D, 4'hA, 0, 1, 1'b0);

        rd_lat = 3;
        for (int n = 0; n < 40; n++) begin
            d0 = 1'($urandom_range(0, 1));
            d1 = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            if (!(d0 | d1 | dw)) d0 = 1'b1;
            dly = $urandom_range(0, 3);
            aw_late = 1'($urandom_range(0, 1));
            run_scn(d0, d1, dw, rnd_addr(), rnd_addr(), rnd_addr(), $urandom,
                    4'($urandom_range(0, 15)), aw_late ? dly : 0, aw_late ? 0 : dly, 1'b0);
        end

        // reset during a write after its AW handshake, then a normal IFU read
        run_scn(1'b0, 1'b0, 1'b1, 32'h8000_0014, 32'h8000_0110, 32'h8000_0210, 32'h1234_5678, 4'h3, 0, 3, 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("reset_mid_write_outputs", all_outs(), '0);
        exp_q.delete();
        model_last_lsu = 1'b1;
        m0_req = 1'b0; r1_req = 1'b0; aw_req = 1'b0; w_req = 1'b0;
        sl_rd_busy = 1'b0; sl_aw_got = 1'b0; sl_w_got = 1'b0;
        drive();
        @(negedge clk);
        chk("reset_held_outputs", all_outs(), '0);
        rst = 1'b1;
        run_scn(1'b1, 1'b0, 1'b0, 32'h8000_0040, 32'h8000_0114, 32'h8000_0214, 32'h0, 4'h0, 0, 0, 1'b0);
        run_scn(1'b1, 1'b1, 1'b1, 32'h8000_0044, 32'h8000_0118, 32'h8000_0218, 32'h5555_AAAA, 4'hC, 1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
